rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter.
// Up to three execution units (ALU, MUL, LSU) compete for two register-file
// write ports. A round-robin pointer picks the search order. The first valid
// requester gets port A. The next valid requester with a different address
// gets port B. Any requester that targets port A's address waits, and that
// wait is counted.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [2:0]              req_valid_i,
    input  logic [3*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [3*DATA_WIDTH-1:0] req_data_i,
    output logic [2:0]              req_ready_o,
    output logic                    we_a_o,
    output logic [ADDR_WIDTH-1:0]   waddr_a_o,
    output logic [DATA_WIDTH-1:0]   wdata_a_o,
    output logic                    we_b_o,
    output logic [ADDR_WIDTH-1:0]   waddr_b_o,
    output logic [DATA_WIDTH-1:0]   wdata_b_o,
    output logic [15:0]             conflict_cnt_o
);

    // Reduce a value in 0..4 to its residue mod 3.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

    logic [1:0]            r_rr;
    logic                  r_we_a;
    logic                  r_we_b;
    logic [ADDR_WIDTH-1:0] r_waddr_a;
    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_a;
    logic [DATA_WIDTH-1:0] r_wdata_b;
    logic [15:0]           r_conflict_cnt;

    logic [ADDR_WIDTH-1:0] w_addr [3];
    logic [DATA_WIDTH-1:0] w_data [3];
    logic [1:0]            w_ord  [3];
    logic [2:0]            w_ready;
    logic                  w_a_vld;
    logic [1:0]            w_a_idx;
    logic                  w_b_vld;
    logic [1:0]            w_b_idx;
    logic                  w_conflict;
    logic [1:0]            w_last_idx;
    logic [1:0]            w_rr_next;

    // Unpack the requester buses and build the rotated search order.
    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        assign w_addr[gi] = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_ord[gi]  = wrap3({1'b0, r_rr} + 3'(gi));
    end

    // Walk the search order to pick slot A and slot B, and flag address clashes with A.
    always_comb begin
        w_ready    = 3'b000;
        w_a_vld    = 1'b0;
        w_a_idx    = 2'd0;
        w_b_vld    = 1'b0;
        w_b_idx    = 2'd0;
        w_conflict = 1'b0;
        if (rst_n && !flush_i) begin
            for (int j = 0; j < 3; j++) begin
                if (req_valid_i[w_ord[j]]) begin
                    if (!w_a_vld) begin
                        w_a_vld           = 1'b1;
                        w_a_idx           = w_ord[j];
                        w_ready[w_ord[j]] = 1'b1;
                    end else if (w_addr[w_ord[j]] == w_addr[w_a_idx]) begin
                        w_conflict = 1'b1;
                    end else if (!w_b_vld) begin
                        w_b_vld           = 1'b1;
                        w_b_idx           = w_ord[j];
                        w_ready[w_ord[j]] = 1'b1;
                    end
                end
            end
        end
        w_last_idx = w_b_vld ? w_b_idx : w_a_idx;
        w_rr_next  = wrap3({1'b0, w_last_idx} + 3'd1);
    end

    // Register the granted writes, advance the pointer, and count conflict cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr           <= 2'd0;
            r_we_a         <= 1'b0;
            r_we_b         <= 1'b0;
            r_waddr_a      <= '0;
            r_waddr_b      <= '0;
            r_wdata_a      <= '0;
            r_wdata_b      <= '0;
            r_conflict_cnt <= 16'd0;
        end else if (flush_i) begin
            r_rr   <= 2'd0;
            r_we_a <= 1'b0;
            r_we_b <= 1'b0;
        end else begin
            r_we_a <= w_a_vld;
            r_we_b <= w_b_vld;
            if (w_a_vld) begin
                r_waddr_a <= w_addr[w_a_idx];
                r_wdata_a <= w_data[w_a_idx];
                r_rr      <= w_rr_next;
            end
            if (w_b_vld) begin
                r_waddr_b <= w_addr[w_b_idx];
                r_wdata_b <= w_data[w_b_idx];
            end
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign req_ready_o    = w_ready;
    assign we_a_o         = r_we_a;
    assign waddr_a_o      = r_waddr_a;
    assign wdata_a_o      = r_wdata_a;
    assign we_b_o         = r_we_b;
    assign waddr_b_o      = r_waddr_b;
    assign wdata_b_o      = r_wdata_b;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [2:0]      valid;
    logic [3*AW-1:0] addr_bus;
    logic [3*DW-1:0] data_bus;
    logic [2:0]      ready;
    logic            we_a, we_b;
    logic [AW-1:0]   waddr_a, waddr_b;
    logic [DW-1:0]   wdata_a, wdata_b;
    logic [15:0]     cnt;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush),
        .req_valid_i    (valid),
        .req_addr_i     (addr_bus),
        .req_data_i     (data_bus),
        .req_ready_o    (ready),
        .we_a_o         (we_a),
        .waddr_a_o      (waddr_a),
        .wdata_a_o      (wdata_a),
        .we_b_o         (we_b),
        .waddr_b_o      (waddr_b),
        .wdata_b_o      (wdata_b),
        .conflict_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pending request contents per requester (0 ALU, 1 MUL, 2 LSU).
    logic [AW-1:0] rq_addr [3];
    logic [DW-1:0] rq_data [3];

    // Behavioural model state.
    int            m_rr;
    int            m_cnt;
    logic          m_we_a, m_we_b;
    logic [AW-1:0] m_waddr_a, m_waddr_b;
    logic [DW-1:0] m_wdata_a, m_wdata_b;
    int            last_ga, last_gb;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Grant decision from the rules: scan requesters in the order rr, rr+1, rr+2.
    task automatic predict(output logic [2:0] rdy, output int ga, output int gb, output bit conf);
        int order[$];
        rdy  = 3'b000;
        ga   = -1;
        gb   = -1;
        conf = 1'b0;
        if (!rst_n || flush) return;
        for (int j = 0; j < 3; j++) order.push_back((m_rr + j) % 3);
        foreach (order[i]) begin
            int k;
            k = order[i];
            if (valid[k]) begin
                if (ga < 0) ga = k;
                else if (rq_addr[k] == rq_addr[ga]) conf = 1'b1;
                else if (gb < 0) gb = k;
            end
        end
        if (ga >= 0) rdy[ga] = 1'b1;
        if (gb >= 0) rdy[gb] = 1'b1;
    endtask

    // One clock cycle: check ready mid-cycle, update the model at the edge, check outputs after it.
    task automatic cycle();
        logic [2:0] rdy;
        int         ga, gb;
        bit         conf;
        for (int k = 0; k < 3; k++) begin
            addr_bus[k*AW +: AW] = rq_addr[k];
            data_bus[k*DW +: DW] = rq_data[k];
        end
        @(negedge clk);
        predict(rdy, ga, gb, conf);
        check("ready", 64'(ready), 64'(rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_rr = 0; m_cnt = 0; m_we_a = 0; m_we_b = 0;
            m_waddr_a = '0; m_waddr_b = '0; m_wdata_a = '0; m_wdata_b = '0;
        end else if (flush) begin
            m_rr = 0; m_we_a = 0; m_we_b = 0;
        end else begin
            m_we_a = (ga >= 0);
            m_we_b = (gb >= 0);
            if (ga >= 0) begin m_waddr_a = rq_addr[ga]; m_wdata_a = rq_data[ga]; end
            if (gb >= 0) begin m_waddr_b = rq_addr[gb]; m_wdata_b = rq_data[gb]; end
            if (ga >= 0) m_rr = (((gb >= 0) ? gb : ga) + 1) % 3;
            if (conf && m_cnt < 65535) m_cnt++;
        end
        last_ga = ga;
        last_gb = gb;
        #1;
        check("we_a",    64'(we_a),    64'(m_we_a));
        check("waddr_a", 64'(waddr_a), 64'(m_waddr_a));
        check("wdata_a", 64'(wdata_a), 64'(m_wdata_a));
        check("we_b",    64'(we_b),    64'(m_we_b));
        check("waddr_b", 64'(waddr_b), 64'(m_waddr_b));
        check("wdata_b", 64'(wdata_b), 64'(m_wdata_b));
        check("cnt",     64'(cnt),     64'(m_cnt));
    endtask

    // Granted requesters drop their request.
    task automatic retire();
        if (last_ga >= 0) valid[last_ga] = 1'b0;
        if (last_gb >= 0) valid[last_gb] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 3'b000;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid[k]   = 1'b1;
        rq_addr[k] = a;
        rq_data[k] = d;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 3'b000;
        addr_bus = '0; data_bus = '0;
        m_rr = 0; m_cnt = 0; m_we_a = 0; m_we_b = 0;
        m_waddr_a = '0; m_waddr_b = '0; m_wdata_a = '0; m_wdata_b = '0;
        last_ga = -1; last_gb = -1;
        for (int k = 0; k < 3; k++) begin rq_addr[k] = '0; rq_data[k] = '0; end

        // Single ALU request.
        do_reset();
        set_req(0, 5'd3, 32'hAA);
        cycle();
        retire();
        check("single_we_a", 64'(we_a), 64'd1);
        check("single_waddr_a", 64'(waddr_a), 64'd3);
        check("single_wdata_a", 64'(wdata_a), 64'hAA);
        check("single_we_b", 64'(we_b), 64'd0);
        cycle();

        // Three distinct addresses: ALU/MUL first, LSU next cycle on port A.
        do_reset();
        set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
        cycle(); retire();
        check("three_waddr_b", 64'(waddr_b), 64'd2);
        cycle(); retire();
        check("three_lsu_a", 64'(waddr_a), 64'd3);
        cycle();

        // ALU and MUL both at address 5.
        do_reset();
        set_req(0, 5'd5, 32'h50); set_req(1, 5'd5, 32'h51);
        cycle(); retire();
        check("conf_cnt1", 64'(cnt), 64'd1);
        cycle(); retire();
        check("conf_mul_a", 64'(wdata_a), 64'h51);
        cycle();

        // All three at address 7.
        do_reset();
        set_req(0, 5'd7, 32'h70); set_req(1, 5'd7, 32'h71); set_req(2, 5'd7, 32'h72);
        for (int i = 0; i < 3; i++) begin cycle(); retire(); end
        check("all7_cnt", 64'(cnt), 64'd2);
        check("all7_last", 64'(wdata_a), 64'h72);
        cycle();

        // Flush with everything valid, then a reset in a grant cycle.
        do_reset();
        set_req(0, 5'd1, 32'hA1); set_req(1, 5'd2, 32'hA2); set_req(2, 5'd3, 32'hA3);
        cycle(); retire();
        set_req(0, 5'd1, 32'hB1); set_req(1, 5'd2, 32'hB2);
        flush = 1'b1;
        cycle();
        check("flush_we_a", 64'(we_a), 64'd0);
        flush = 1'b0;
        cycle(); retire();
        set_req(0, 5'd4, 32'hC1); set_req(1, 5'd6, 32'hC2);
        rst_n = 1'b0;
        cycle();
        check("rst_we_a", 64'(we_a), 64'd0);
        rst_n = 1'b1;
        valid = 3'b000;
        cycle();

        // Randomized traffic with occasional flush and reset.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (!valid[k] && ($urandom_range(0, 1) == 1))
                    set_req(k, 5'($urandom_range(0, 3)), $urandom);
            end
            flush = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
            retire();
        end
        flush = 1'b0;
        rst_n = 1'b1;

        // Saturation: a conflict every cycle until the counter pins at 0xFFFF.
        do_reset();
        set_req(0, 5'd5, 32'hD0); set_req(1, 5'd5, 32'hD1);
        for (int i = 0; i < 65534; i++) cycle();
        check("sat_fffe", 64'(cnt), 64'hFFFE);
        cycle();
        cycle();
        check("sat_ffff", 64'(cnt), 64'hFFFF);
        cycle();
        check("sat_hold", 64'(cnt), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
